// File: rtl/scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered data
// and optional leading-zero blanking. Outputs are registered from next-state values.
module scan_ctrl #(
    parameter int DIV = 1000,
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        lzb,
    output logic [6:0]  SEG,
    output logic [3:0]  DIG,
    output logic        pend
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t      r_state, w_stateNext;
    logic [1:0]  r_idx, w_idxNext;
    logic [15:0] r_cnt, w_cntNext;
    logic [15:0] r_active, w_activeNext;
    logic [15:0] r_pending, w_pendingNext;
    logic        r_pend, w_pendNext;
    logic [6:0]  r_seg, w_segNext;
    logic [3:0]  r_dig, w_digNext;
    logic        w_frameEnd;
    logic [3:0]  w_nibble;
    logic        w_leadZero;

    function automatic logic [6:0] enc(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    always_comb begin
        w_stateNext   = r_state;
        w_idxNext     = r_idx;
        w_cntNext     = r_cnt + 16'd1;
        w_activeNext  = r_active;
        w_pendingNext = r_pending;
        w_pendNext    = r_pend;
        w_segNext     = 7'h00;
        w_digNext     = 4'hF;
        w_frameEnd    = 1'b0;
        w_nibble      = 4'h0;
        w_leadZero    = 1'b0;

        case (r_state)
            SHOW: begin
                if (r_cnt == DIV_LAST) begin
                    w_cntNext   = 16'd0;
                    w_stateNext = BLANK;
                end
            end
            BLANK: begin
                if (r_cnt == GAP_LAST) begin
                    w_cntNext   = 16'd0;
                    w_idxNext   = r_idx + 2'd1;
                    w_stateNext = SHOW;
                    w_frameEnd  = (r_idx == 2'd3);
                end
            end
            default: begin
                w_cntNext   = 16'd0;
                w_stateNext = SHOW;
            end
        endcase

        // A load landing on the frame boundary bypasses the pending buffer.
        if (w_frameEnd && load) begin
            w_activeNext = data;
            w_pendNext   = 1'b0;
        end else if (w_frameEnd && r_pend) begin
            w_activeNext = r_pending;
            w_pendNext   = 1'b0;
        end else if (load) begin
            w_pendingNext = data;
            w_pendNext    = 1'b1;
        end

        case (w_idxNext)
            2'd0: begin
                w_nibble   = w_activeNext[3:0];
                w_leadZero = 1'b0;
            end
            2'd1: begin
                w_nibble   = w_activeNext[7:4];
                w_leadZero = (w_activeNext[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble   = w_activeNext[11:8];
                w_leadZero = (w_activeNext[15:8] == 8'h00);
            end
            default: begin
                w_nibble   = w_activeNext[15:12];
                w_leadZero = (w_activeNext[15:12] == 4'h0);
            end
        endcase

        if (w_stateNext == SHOW) begin
            w_digNext = ~(4'b0001 << w_idxNext);
            w_segNext = (lzb && w_leadZero) ? 7'h00 : enc(w_nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SHOW;
            r_idx     <= 2'd0;
            r_cnt     <= 16'd0;
            r_active  <= 16'h0000;
            r_pending <= 16'h0000;
            r_pend    <= 1'b0;
            r_seg     <= 7'h7E;
            r_dig     <= 4'b1110;
        end else begin
            r_state   <= w_stateNext;
            r_idx     <= w_idxNext;
            r_cnt     <= w_cntNext;
            r_active  <= w_activeNext;
            r_pending <= w_pendingNext;
            r_pend    <= w_pendNext;
            r_seg     <= w_segNext;
            r_dig     <= w_digNext;
        end
    end

    assign SEG  = r_seg;
    assign DIG  = r_dig;
    assign pend = r_pend;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: directed scenarios then random traffic, all checked
// against a frame-position model of the display.
module tb_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = DIV + GAP;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        lzb = 1'b0;
    logic [6:0]  SEG;
    logic [3:0]  DIG;
    logic        pend;

    int checkCount = 0;
    int passCount  = 0;

    int          mPos = 0;
    logic [15:0] mActive = 16'h0000;
    logic [15:0] mPending = 16'h0000;
    logic        mPend = 1'b0;
    logic        mLzb = 1'b0;

    logic [6:0] encTable [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (data),
        .lzb  (lzb),
        .SEG  (SEG),
        .DIG  (DIG),
        .pend (pend)
    );

    // Drive one cycle of inputs, clock it, and advance the model across that edge.
    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] d, input logic z);
        logic boundary;
        rst  = r;
        load = l;
        data = d;
        lzb  = z;
        @(posedge clk);
        if (r) begin
            mPos     = 0;
            mActive  = 16'h0000;
            mPending = 16'h0000;
            mPend    = 1'b0;
        end else begin
            boundary = (mPos == FRAME - 1);
            mPos     = (mPos + 1) % FRAME;
            if (boundary && l) begin
                mActive = d;
                mPend   = 1'b0;
            end else if (boundary && mPend) begin
                mActive = mPending;
                mPend   = 1'b0;
            end else if (l) begin
                mPending = d;
                mPend    = 1'b1;
            end
        end
        mLzb = z;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        int         digit;
        int         offset;
        logic [3:0] nib;
        logic       blank;
        logic [6:0] expSeg;
        logic [3:0] expDig;
        digit  = mPos / SLOT;
        offset = mPos % SLOT;
        if (offset >= DIV) begin
            expDig = 4'hF;
            expSeg = 7'h00;
        end else begin
            expDig = ~(4'h1 << digit);
            nib    = 4'(mActive >> (4 * digit));
            blank  = mLzb && (digit > 0) && ((mActive >> (4 * digit)) == 16'h0000);
            expSeg = blank ? 7'h00 : encTable[nib];
        end
        checkCount++;
        assert (SEG === expSeg) passCount++;
        else $error("FAIL %s SEG pos=%0d actual=%h expected=%h", tag, mPos, SEG, expSeg);
        checkCount++;
        assert (DIG === expDig) passCount++;
        else $error("FAIL %s DIG pos=%0d actual=%b expected=%b", tag, mPos, DIG, expDig);
        checkCount++;
        assert (pend === mPend) passCount++;
        else $error("FAIL %s pend pos=%0d actual=%b expected=%b", tag, mPos, pend, mPend);
    endtask

    task automatic stepCheck(input logic r, input logic l, input logic [15:0] d, input logic z,
                             input string tag);
        applyStimulus(r, l, d, z);
        checkOutput(tag);
    endtask

    task automatic advanceTo(input int target, input logic z, input string tag);
        for (int i = 0; i < FRAME && mPos != target; i++) stepCheck(1'b0, 1'b0, 16'h0000, z, tag);
    endtask

    initial begin
        logic r;
        logic l;
        logic z;
        logic [15:0] d;

        stepCheck(1'b1, 1'b0, 16'h0000, 1'b0, "reset");
        stepCheck(1'b1, 1'b1, 16'hFFFF, 1'b0, "reset_load_drop");
        advanceTo(4, 1'b0, "idle_frame");

        stepCheck(1'b0, 1'b1, 16'h12AF, 1'b0, "load_12AF");
        for (int i = 0; i < FRAME; i++) stepCheck(1'b0, 1'b0, 16'h0000, 1'b0, "frame_12AF");
        advanceTo(FRAME - 1, 1'b0, "frame_12AF");

        stepCheck(1'b0, 1'b0, 16'h0000, 1'b0, "double_load");
        stepCheck(1'b0, 1'b1, 16'h1111, 1'b0, "load_1111");
        for (int i = 0; i < 3; i++) stepCheck(1'b0, 1'b0, 16'h0000, 1'b0, "double_load");
        stepCheck(1'b0, 1'b1, 16'h2222, 1'b0, "load_2222");
        advanceTo(FRAME - 1, 1'b0, "double_load");
        stepCheck(1'b0, 1'b0, 16'h0000, 1'b0, "frame_2222");
        advanceTo(FRAME - 1, 1'b0, "frame_2222");

        stepCheck(1'b0, 1'b1, 16'h0070, 1'b1, "boundary_load");
        advanceTo(FRAME - 1, 1'b1, "lzb_0070");

        stepCheck(1'b0, 1'b0, 16'h0000, 1'b1, "lzb_0070");
        stepCheck(1'b0, 1'b1, 16'h0000, 1'b1, "load_0000");
        advanceTo(FRAME - 1, 1'b1, "lzb_0070");
        stepCheck(1'b0, 1'b0, 16'h0000, 1'b1, "lzb_0000");
        advanceTo(FRAME - 1, 1'b1, "lzb_0000");

        stepCheck(1'b0, 1'b0, 16'h0000, 1'b0, "pre_reset");
        stepCheck(1'b0, 1'b1, 16'hBEEF, 1'b0, "load_BEEF");
        advanceTo(2 * SLOT + 1, 1'b0, "pre_reset");
        stepCheck(1'b1, 1'b0, 16'h0000, 1'b0, "reset_mid_show");
        advanceTo(FRAME - 1, 1'b0, "after_reset");
        stepCheck(1'b0, 1'b0, 16'h0000, 1'b0, "pending_lost");
        advanceTo(FRAME - 1, 1'b0, "pending_lost");

        z = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 5) == 0);
            d = 16'($urandom);
            if ($urandom_range(0, 9) == 0) z = ~z;
            stepCheck(r, l, d, z, "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
